param_sync_fifo: RTL
====================

Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit buffer.
- Configurable data width and depth, explicit READ handshake, full/empty and programmable almost-full/almost-empty flags, occupancy count, overflow/underflow pulses.
- Sits between the parallel data producer and the serialiser/consumer stages; flags drive upstream back-pressure.

Parameters:
- DATA_WIDTH, 8, bits per word.
- DEPTH, 8, number of entries; power of 2, minimum 2.
- AF_THRESH, DEPTH-2, almost_Full asserted when Count >= AF_THRESH.
- AE_THRESH, 2, almost_Empty asserted when Count <= AE_THRESH.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DATA_IN  in  DATA_WIDTH  write data.
- WRITE  in  1  write request.
- READ  in  1  read request.
- DATA_OUT  out  DATA_WIDTH  read data.
- Valid  out  1  DATA_OUT holds a popped word.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- almost_Full  out  1  Count >= AF_THRESH.
- almost_Empty  out  1  Count <= AE_THRESH.
- Overflow  out  1  one-cycle pulse: rejected write.
- Underflow  out  1  one-cycle pulse: rejected read.
- Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (RESET=0, asynchronous): pointers=0, Count=0, DATA_OUT=0, Valid=0, Overflow=0, Underflow=0. Empty=1, almost_Empty=1, Full=0, almost_Full=0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Write accepted: WRITE && (!Full || read_accepted). Stores DATA_IN at wr_ptr, then wr_ptr++.
- Read accepted: READ && !Empty.
  - DATA_OUT <= mem[rd_ptr], rd_ptr++.
  - Valid=1 the next cycle; latency is 1 clock.
  - If no read is accepted, Valid=0 and DATA_OUT holds its last value.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags: Full, Empty, almost_Full and almost_Empty decode combinationally from registered Count, so they update in the cycle after the causing edge.
- Simultaneous READ+WRITE:
  - When full: both accepted, Count stays DEPTH, no Overflow.
  - When empty: write accepted, read rejected, Underflow pulses, Count -> 1.
- Overflow=1 for one cycle after WRITE && Full && !READ. Data is dropped and state is unchanged.
- Underflow=1 for one cycle after READ && Empty. State is unchanged.
- Reset mid-operation clears everything immediately; pending writes are lost.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - DATA_OUT shows the head word and Valid=1 whenever Count>0.
  - READ while Valid pops; the next word or Valid=0 appears the cycle after.
  - Write into an empty FIFO gives Valid=1 one cycle after the write edge.
  - Underflow = READ && !Valid.
- Undefined: standard registered-read mode as described under Behaviour.

Decomposition:
- Shared header fifo_defs.vh:
  - DATA_WIDTH and DEPTH default constants.
  - Pointer and count width macro based on $clog2.
  - Shared by the FIFO, tester and synthesised netlist bench.
- Sub-module fifo_mem:
  - Parameters DATA_WIDTH and DEPTH.
  - One synchronous write port (CLK, we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Top level holds pointers, count, flags and output register.

Test Plan:
- Reset, then 8 writes of 0x01..0x08 with DEPTH=8: Count 1..8; almost_Full after the 6th write; Full after the 8th.
- 9th write 0xFF while full: Overflow one-cycle pulse; Count stays 8; subsequent reads return 0x01..0x08 only.
- 8 reads: DATA_OUT=0x01..0x08, each one cycle after READ with Valid=1; Empty after the last; almost_Empty once Count<=2.
- READ on empty: Underflow pulse, Valid=0, Count=0. READ+WRITE 0xA5 on empty: Count=1, Underflow pulse.
- Full FIFO with READ+WRITE 0x55 for 16 cycles: Count stays 8, no Overflow, output order preserved across pointer wrap.
- RESET low asynchronously mid-stream at Count=5: outputs clear before the next CLK edge, Empty=1; FWFT build: write 0x3C into empty gives Valid=1 and DATA_OUT=0x3C one cycle later with no READ.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Optional build macro: FIFO_FWFT_EN (first-word-fall-through read path).
package param_sync_fifo_pkg;

    // Default geometry, matching the previous 8-bit, 8-deep buffer.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so a completely full FIFO is representable.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// The contents are deliberately not reset.
module fifo_mem
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                          CLK,
    input  logic                          we,
    input  logic [ptr_width(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [ptr_width(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store the word on the rising edge when enabled.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Optional build macro: FIFO_FWFT_EN selects first-word-fall-through output;
// without it, reads are registered with one clock of latency.
//
// Handshake: WRITE and READ are requests, not valid/ready pairs. A write is
// taken when WRITE && (!Full || read accepted); a read is taken when
// READ && !Empty. A rejected request is reported by a one-cycle Overflow or
// Underflow pulse. Valid marks a cycle in which DATA_OUT holds a popped word
// (registered mode) or the current head word (FWFT mode); the upstream side
// uses Full/almost_Full as back-pressure.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    input  logic                    WRITE,
    input  logic                    READ,
    output logic [DATA_WIDTH-1:0]   DATA_OUT,
    output logic                    Valid,
    output logic                    Full,
    output logic                    Empty,
    output logic                    almost_Full,
    output logic                    almost_Empty,
    output logic                    Overflow,
    output logic                    Underflow,
    output logic [$clog2(DEPTH):0]  Count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_acc;
    logic                  wr_acc;

    // Acceptance: a full FIFO still takes a write when a read frees a slot
    // in the same cycle; an empty FIFO never serves a read.
    always_comb begin
        rd_acc = READ && !Empty;
        wr_acc = WRITE && (!Full || rd_acc);
    end

    // Status flags decode from the registered occupancy.
    always_comb begin
        Empty        = (count_q == '0);
        Full         = (count_q == CNT_W'(DEPTH));
        almost_Full  = (count_q >= CNT_W'(AF_THRESH));
        almost_Empty = (count_q <= CNT_W'(AE_THRESH));
        Count        = count_q;
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (DATA_IN),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Pointers wrap naturally modulo DEPTH; occupancy moves only on an
    // unbalanced write or read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Error pulses: last exactly one cycle after the rejected request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= WRITE && Full && !READ;
            Underflow <= READ && Empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; zero is shown while nothing is stored.
    always_comb begin
        Valid    = !Empty;
        DATA_OUT = Valid ? mem_rdata : '0;
    end
`else
    // Registered read: popped word appears one clock after the accepted read
    // and holds until the next one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_OUT <= '0;
            Valid    <= 1'b0;
        end else begin
            Valid <= rd_acc;
            if (rd_acc) begin
                DATA_OUT <= mem_rdata;
            end
        end
    end
`endif

endmodule
